// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - PC/pipeline-register sequencing for load-use, MUL occupancy and BEQ/J flushes
module pipeline_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_taken_i,
    input  logic             id_jump_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_is_mul_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_bubble_o,
    output logic             exmem_bubble_o,
    output logic             mul_busy_o,
    output logic             mul_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_HOLD = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] mul_cnt;
    logic       mul_hold;
    logic       load_use;
    logic       flush;

    always_comb begin
        mul_hold = ((state == RUN) && ex_is_mul_i) ||
                   ((state == MUL_HOLD) && (mul_cnt != 4'd0));
        // Load-use is only checked in RUN; a MUL hold already freezes ID.
        load_use = (state == RUN) && !mul_hold && ex_mem_read_i && (ex_rt_i != 5'd0) &&
                   ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
        flush    = !mul_hold && !load_use && (id_branch_taken_i || id_jump_i);

        pc_we_o        = !(mul_hold || load_use);
        ifid_we_o      = !(mul_hold || load_use);
        idex_we_o      = !mul_hold;
        idex_bubble_o  = load_use;
        exmem_bubble_o = mul_hold;
        ifid_flush_o   = flush;
        mul_busy_o     = (state == MUL_HOLD);
        mul_done_o     = (state == MUL_HOLD) && (mul_cnt == 4'd0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= RUN;
            mul_cnt     <= 4'd0;
            stall_cnt_o <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_is_mul_i) begin
                        state   <= MUL_HOLD;
                        mul_cnt <= 4'(MUL_CYCLES - 2);
                    end
                end
                MUL_HOLD: begin
                    if (mul_cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= RUN;
                    mul_cnt <= 4'd0;
                end
            endcase
            if (!pc_we_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl against an occupancy-count model
module tb_pipeline_stall_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic [4:0]       id_rs_i = '0;
    logic [4:0]       id_rt_i = '0;
    logic             id_uses_rt_i = 1'b0;
    logic             id_branch_taken_i = 1'b0;
    logic             id_jump_i = 1'b0;
    logic             ex_mem_read_i = 1'b0;
    logic [4:0]       ex_rt_i = '0;
    logic             ex_is_mul_i = 1'b0;
    logic             pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o;
    logic             idex_bubble_o, exmem_bubble_o, mul_busy_o, mul_done_o;
    logic [CNT_W-1:0] stall_cnt_o;

    pipeline_stall_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .id_rs_i           (id_rs_i),
        .id_rt_i           (id_rt_i),
        .id_uses_rt_i      (id_uses_rt_i),
        .id_branch_taken_i (id_branch_taken_i),
        .id_jump_i         (id_jump_i),
        .ex_mem_read_i     (ex_mem_read_i),
        .ex_rt_i           (ex_rt_i),
        .ex_is_mul_i       (ex_is_mul_i),
        .pc_we_o           (pc_we_o),
        .ifid_we_o         (ifid_we_o),
        .ifid_flush_o      (ifid_flush_o),
        .idex_we_o         (idex_we_o),
        .idex_bubble_o     (idex_bubble_o),
        .exmem_bubble_o    (exmem_bubble_o),
        .mul_busy_o        (mul_busy_o),
        .mul_done_o        (mul_done_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] ctrl;
        int         cnt;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   stop_mon = 1'b0;

    // Model: mul_left is how many more cycles the MUL still occupies EX after this one.
    int m_left = 0;
    int m_cnt  = 0;

    task automatic step(input logic rst, input logic mul, input logic mr, input logic br,
                        input logic j, input logic urt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] ert);
        logic hold, done, busy, lu, fl, pcwe;
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_n_i = rst; ex_is_mul_i = mul; ex_mem_read_i = mr; id_branch_taken_i = br;
        id_jump_i = j; id_uses_rt_i = urt; id_rs_i = rs; id_rt_i = rt; ex_rt_i = ert;
        cyc++;
        if (!rst) begin
            m_left = 0;
            m_cnt  = 0;
        end
        hold = (m_left == 0 && mul) || (m_left > 1);
        done = (m_left == 1);
        busy = (m_left > 0);
        lu   = (m_left == 0) && !mul && mr && (ert != 0) && (ert == rs || (urt && ert == rt));
        fl   = !hold && !lu && (br || j);
        pcwe = !(hold || lu);
        e.ctrl = {pcwe, pcwe, fl, !hold, lu, hold, busy, done};
        e.cnt  = m_cnt;
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (rst) begin
            if (!pcwe) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (m_left == 0 && mul) m_left = MUL_CYCLES - 1;
            else if (m_left > 0) m_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk_i);
            if (stop_mon) break;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o,
                       idex_bubble_o, exmem_bubble_o, mul_busy_o, mul_done_o};
                total++;
                if (act !== e.ctrl) begin
                    bad++;
                    $display("FAIL ctrl cyc=%0d got=%b want=%b (pc,ifid,flush,idex,bub,exbub,busy,done)",
                             e.cyc, act, e.ctrl);
                end
                total++;
                if (int'(stall_cnt_o) != e.cnt || $isunknown(stall_cnt_o)) begin
                    bad++;
                    $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.cyc, stall_cnt_o, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        do_reset(2);
        idle(2);
        // Load-use: rs match, ex_rt=0, rt match without/with uses_rt.
        step(1, 0, 1, 0, 0, 0, 5'd5, 5'd0, 5'd5);
        step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(1, 0, 1, 0, 0, 0, 5'd1, 5'd7, 5'd7);
        step(1, 0, 1, 0, 0, 1, 5'd1, 5'd7, 5'd7);
        idle(1);
        // Single MUL, then back-to-back MULs.
        do_reset(1);
        for (int i = 0; i < MUL_CYCLES; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 2 * MUL_CYCLES; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Flush alone, jump during load-use, branch during MUL hold.
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 5'd3, 5'd0, 5'd3);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 0, 0, 0, 0);
        idle(3);
        // Reset in the second cycle of a MUL hold.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        do_reset(1);
        idle(3);
        // Saturation with a sustained load-use.
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 1, 5'd2, 5'd9, 5'd9);
        idle(2);
        do_reset(1);
        // Randomized traffic; MUL is held in EX for its full occupancy like the real pipeline.
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            logic mul;
            if ($urandom_range(0, 63) == 0) begin
                do_reset(1);
                n = 0;
                continue;
            end
            if (n > 0) begin
                mul = 1'b1;
                n--;
            end else if ($urandom_range(0, 9) == 0) begin
                mul = 1'b1;
                n = MUL_CYCLES - 1;
            end else begin
                mul = ($urandom_range(0, 49) == 0);
            end
            step(1, mul, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        idle(1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk_i);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        stop_mon = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the ID and EX stages, consumes the decoded control flags carried in IF/ID and ID/EX, and drives the write-enables, bubble inserts and flushes of the PC and pipeline registers. It handles load-use stalls, multi-cycle MUL occupancy of EX, and taken BEQ/J flushes. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MUL_CYCLES, 4, EX-stage occupancy of a MUL in cycles; legal range 2..16.
- CNT_W, 16, width of the stall-cycle counter.

- clk_i  in  1  clock; all state updates on its rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- id_rs_i  in  5  rs field of the instruction in ID.
- id_rt_i  in  5  rt field of the instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt as a source (R-type, BEQ, SW).
- id_branch_taken_i  in  1  BEQ in ID resolved taken.
- id_jump_i  in  1  J in ID.
- ex_mem_read_i  in  1  instruction in EX is LW (ID/EX MEM_cs=1, MEM_we=0).
- ex_rt_i  in  5  destination register of the instruction in EX.
- ex_is_mul_i  in  1  instruction in EX is MUL.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_we_o  out  1  ID/EX write enable.
- idex_bubble_o  out  1  ID/EX loads all-zero control (bubble).
- exmem_bubble_o  out  1  EX/MEM loads all-zero control.
- mul_busy_o  out  1  FSM in MUL_HOLD.
- mul_done_o  out  1  final MUL cycle; EX/MEM captures the product.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_we_o=0.

## Operation
- FSM states: RUN, MUL_HOLD. 4-bit down-counter mul_cnt.
- RUN, ex_is_mul_i=1: MUL hold this cycle (see outputs); next state MUL_HOLD, mul_cnt <= MUL_CYCLES-2.
- MUL_HOLD, mul_cnt!=0: MUL hold; mul_cnt decrements.
- MUL_HOLD, mul_cnt==0: no hold; mul_done_o=1; next state RUN. ex_is_mul_i ignored in MUL_HOLD.
- MUL hold outputs: pc_we_o=0, ifid_we_o=0, idex_we_o=0, exmem_bubble_o=1, ifid_flush_o=0, idex_bubble_o=0.
- Load-use (RUN only, not MUL hold): ex_mem_read_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)). Outputs: pc_we_o=0, ifid_we_o=0, idex_we_o=1, idex_bubble_o=1. Combinational, one cycle per occurrence, no state.
- Flush: (id_branch_taken_i || id_jump_i) with neither MUL hold nor load-use active -> ifid_flush_o=1, all write-enables 1. Under a stall the flush is suppressed; the branch is re-evaluated when ID releases.
- Priority: MUL hold > load-use > flush > normal (all we=1, bubbles/flush=0).
- MUL and LW cannot both be in EX; priority still applies if inputs conflict.
- stall_cnt_o increments on every clock with pc_we_o=0; holds at 2^CNT_W-1.

## Timing
- Outputs are combinational from registered state and current inputs; state, mul_cnt and stall_cnt_o are registered.
- Reset (rst_n_i=0): state=RUN, mul_cnt=0, stall_cnt_o=0, immediately, asynchronously. With idle inputs: pc_we_o=1, ifid_we_o=1, idex_we_o=1, all other outputs 0.
- MUL entering EX at cycle t: hold at t..t+MUL_CYCLES-2; mul_done_o=1 and release at t+MUL_CYCLES-1. EX occupancy is MUL_CYCLES cycles and adds MUL_CYCLES-1 stall cycles.
- Load-use: exactly 1 stall cycle per dependent pair.
- Reset mid-MUL_HOLD: hold drops in the same cycle reset asserts. The partial MUL is discarded; the fetch unit restarts from the reset PC.
- Back-to-back MULs: the second is seen in RUN the cycle after release and starts a fresh hold with no gap cycle.

## Test plan
- Reset: rst_n_i=0, inputs 0 -> pc_we_o=1, ifid_we_o=1, idex_we_o=1, bubbles/flush/mul_* = 0, stall_cnt_o=0.
- Load-use: ex_mem_read_i=1, ex_rt_i=5, id_rs_i=5 for 1 cycle -> pc_we_o=0, idex_bubble_o=1 that cycle, stall_cnt_o=1. ex_rt_i=0 -> no stall. rt match with id_uses_rt_i=0 -> no stall.
- MUL, MUL_CYCLES=4: ex_is_mul_i=1 at t -> pc_we_o=0, exmem_bubble_o=1 at t,t+1,t+2; at t+3 pc_we_o=1, mul_done_o=1; mul_busy_o high t+1..t+3; stall_cnt_o=3.
- Flush: id_branch_taken_i=1 with no hazard -> ifid_flush_o=1 for 1 cycle, pc_we_o=1. id_jump_i=1 during load-use -> ifid_flush_o=0, idex_bubble_o=1.
- Reset at t+1 of a MUL_CYCLES=4 MUL -> pc_we_o=1 immediately; after release, state=RUN, mul_busy_o=0, stall_cnt_o=0.
- Saturation, CNT_W=4: load-use held 20 cycles -> stall_cnt_o reaches 15 and stays at 15.
